// File: rtl/user_proj_timer_mc.sv
// ---------------------------------------------------------------------------
// user_proj_timer_mc
//
// Purpose:
//   Multi-channel timer. One shared prescaler produces a tick; N_CH
//   independent channels count on that tick. Each channel can be in one of
//   four modes: OFF, ONESHOT, PERIODIC (toggle on terminal count) or PWM.
//   Period and compare values are double-buffered: writes land in shadow
//   registers and move to the active registers at terminal count (TC), at a
//   ctrl write, or at once while the channel is OFF.
//
// Optional feature (compile-time macro TIMER_CAPTURE_EN):
//   Adds per-channel capture inputs. Each cap_in bit goes through a 2-flop
//   synchroniser; a rising edge of the synchronised signal latches the
//   channel count into cap_val. Without the macro the cap_in/cap_val ports
//   and the synchroniser flops do not exist.
//
// Ports:
//   wb_clk_i   in   1            clock
//   wb_rst_i   in   1            synchronous reset, active-high
//   cfg_we     in   1            config write strobe (one cycle per write)
//   cfg_ch     in   4            target channel, writes to cfg_ch>=N_CH ignored
//   cfg_sel    in   2            0=period 1=compare 2=ctrl(mode) 3=prescaler div
//   cfg_wdata  in   CNT_W        write data
//   ch_out     out  N_CH         registered channel outputs
//   ch_oeb     out  N_CH         1 while the channel is OFF
//   ch_done    out  N_CH         one-cycle pulse after each terminal count
//   cap_in     in   N_CH         capture inputs           (TIMER_CAPTURE_EN)
//   cap_val    out  N_CH*CNT_W   last captured counts     (TIMER_CAPTURE_EN)
// ---------------------------------------------------------------------------
module user_proj_timer_mc #(
  parameter int N_CH  = 4,
  parameter int CNT_W = 16,
  parameter int PRE_W = 8
) (
  input  logic                   wb_clk_i,
  input  logic                   wb_rst_i,
  input  logic                   cfg_we,
  input  logic [3:0]             cfg_ch,
  input  logic [1:0]             cfg_sel,
  input  logic [CNT_W-1:0]       cfg_wdata,
  output logic [N_CH-1:0]        ch_out,
  output logic [N_CH-1:0]        ch_oeb,
  output logic [N_CH-1:0]        ch_done
`ifdef TIMER_CAPTURE_EN
  ,
  input  logic [N_CH-1:0]        cap_in,
  output logic [N_CH*CNT_W-1:0]  cap_val
`endif
);

  typedef enum logic [1:0] {
    MODE_OFF      = 2'd0,
    MODE_ONESHOT  = 2'd1,
    MODE_PERIODIC = 2'd2,
    MODE_PWM      = 2'd3
  } mode_t;

  localparam logic [4:0] N_CH_LIM = 5'(N_CH);

  // Writes addressed to a non-existent channel are dropped entirely,
  // including the global prescaler divider.
  logic ch_valid;
  logic div_wr;
  assign ch_valid = ({1'b0, cfg_ch} < N_CH_LIM);
  assign div_wr   = cfg_we && ch_valid && (cfg_sel == 2'd3);

  // -------------------------------------------------------------------------
  // Shared prescaler: pre_cnt runs 0..div, tick on the div value.
  // -------------------------------------------------------------------------
  logic [PRE_W-1:0] div_reg;
  logic [PRE_W-1:0] pre_cnt_reg;
  logic             tick;

  assign tick = (pre_cnt_reg == div_reg);

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      div_reg     <= '0;
      pre_cnt_reg <= '0;
    end else if (div_wr) begin
      div_reg     <= cfg_wdata[PRE_W-1:0];
      pre_cnt_reg <= '0;
    end else if (tick) begin
      pre_cnt_reg <= '0;
    end else begin
      pre_cnt_reg <= pre_cnt_reg + PRE_W'(1);
    end
  end

  // -------------------------------------------------------------------------
  // Channels
  // -------------------------------------------------------------------------
  for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
    mode_t            mode_reg,    mode_next;
    logic [CNT_W-1:0] cnt_reg,     cnt_next;
    logic [CNT_W-1:0] per_sh_reg,  per_sh_next;
    logic [CNT_W-1:0] cmp_sh_reg,  cmp_sh_next;
    logic [CNT_W-1:0] per_act_reg, per_act_next;
    logic [CNT_W-1:0] cmp_act_reg, cmp_act_next;
    logic             out_reg,     out_next;
    logic             done_reg,    done_next;
    logic             oeb_reg;

    logic             wr_ch, wr_per, wr_cmp, wr_ctl;
    logic             is_off, tc;
    logic [CNT_W-1:0] per_src, cmp_src, cnt_inc;

    assign wr_ch  = cfg_we && (cfg_ch == 4'(gi));
    assign wr_per = wr_ch && (cfg_sel == 2'd0);
    assign wr_cmp = wr_ch && (cfg_sel == 2'd1);
    assign wr_ctl = wr_ch && (cfg_sel == 2'd2);

    assign is_off = (mode_reg == MODE_OFF);
    assign tc     = !is_off && tick && (cnt_reg == per_act_reg);

    // Value to load into active: a same-cycle write bypasses the shadow.
    assign per_src = wr_per ? cfg_wdata : per_sh_reg;
    assign cmp_src = wr_cmp ? cfg_wdata : cmp_sh_reg;
    assign cnt_inc = cnt_reg + CNT_W'(1);

    always_comb begin
      mode_next    = mode_reg;
      cnt_next     = cnt_reg;
      per_sh_next  = per_src;
      cmp_sh_next  = cmp_src;
      per_act_next = per_act_reg;
      cmp_act_next = cmp_act_reg;
      out_next     = out_reg;
      done_next    = 1'b0;

      if (wr_ctl) begin
        // A ctrl write restarts the channel and overrides any TC this cycle.
        mode_next    = mode_t'(cfg_wdata[1:0]);
        cnt_next     = '0;
        out_next     = (cfg_wdata[1:0] == MODE_ONESHOT);
        per_act_next = per_sh_reg;
        cmp_act_next = cmp_sh_reg;
      end else if (is_off) begin
        cnt_next     = '0;
        out_next     = 1'b0;
        per_act_next = per_src;
        cmp_act_next = cmp_src;
      end else if (tick) begin
        if (tc) begin
          cnt_next     = '0;
          done_next    = 1'b1;
          per_act_next = per_src;
          cmp_act_next = cmp_src;
          unique case (mode_reg)
            MODE_ONESHOT: begin
              out_next  = 1'b0;
              mode_next = MODE_OFF;
            end
            MODE_PERIODIC: out_next = !out_reg;
            // New period starts at 0 with the freshly loaded compare.
            MODE_PWM:      out_next = (cmp_src != '0);
            default:       out_next = 1'b0;
          endcase
        end else begin
          cnt_next = cnt_inc;
          if (mode_reg == MODE_PWM) begin
            out_next = (cnt_inc < cmp_act_reg);
          end
        end
      end
    end

    always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
        mode_reg    <= MODE_OFF;
        cnt_reg     <= '0;
        per_sh_reg  <= '0;
        cmp_sh_reg  <= '0;
        per_act_reg <= '0;
        cmp_act_reg <= '0;
        out_reg     <= 1'b0;
        done_reg    <= 1'b0;
        oeb_reg     <= 1'b1;
      end else begin
        mode_reg    <= mode_next;
        cnt_reg     <= cnt_next;
        per_sh_reg  <= per_sh_next;
        cmp_sh_reg  <= cmp_sh_next;
        per_act_reg <= per_act_next;
        cmp_act_reg <= cmp_act_next;
        out_reg     <= out_next;
        done_reg    <= done_next;
        oeb_reg     <= (mode_next == MODE_OFF);
      end
    end

    assign ch_out[gi]  = out_reg;
    assign ch_oeb[gi]  = oeb_reg;
    assign ch_done[gi] = done_reg;

`ifdef TIMER_CAPTURE_EN
    // Two sync flops plus one history flop for edge detection; the latched
    // value is the count as updated on the capture edge.
    logic             sync1_reg, sync2_reg, sync3_reg;
    logic [CNT_W-1:0] cap_reg;
    logic             cap_rise;

    assign cap_rise = sync2_reg && !sync3_reg;

    always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
        sync1_reg <= 1'b0;
        sync2_reg <= 1'b0;
        sync3_reg <= 1'b0;
        cap_reg   <= '0;
      end else begin
        sync1_reg <= cap_in[gi];
        sync2_reg <= sync1_reg;
        sync3_reg <= sync2_reg;
        if (cap_rise && !is_off) begin
          cap_reg <= cnt_next;
        end
      end
    end

    assign cap_val[gi*CNT_W +: CNT_W] = cap_reg;
`endif
  end

endmodule
